// File: rtl/baud_tick_gen_mc_if.sv
// rtl/baud_tick_gen_mc_if.sv - run/config/tick signal bundle for baud_tick_gen_mc
interface baud_tick_gen_mc_if #(
  parameter int CHANNELS  = 2,
  parameter int ACC_WIDTH = 24,
  parameter int CH_W      = 1,
  parameter int OS_W      = 4
);
  logic [CHANNELS-1:0]      enable;
  logic [CHANNELS-1:0]      resync;
  logic                     cfg_wr;
  logic [CH_W-1:0]          cfg_chan;
  logic [ACC_WIDTH-1:0]     cfg_inc;
  logic [CHANNELS-1:0]      tick_os;
  logic [CHANNELS-1:0]      tick_bit;
  logic [CHANNELS*OS_W-1:0] os_phase;

  modport master (
    output enable, resync, cfg_wr, cfg_chan, cfg_inc,
    input  tick_os, tick_bit, os_phase
  );

  modport slave (
    input  enable, resync, cfg_wr, cfg_chan, cfg_inc,
    output tick_os, tick_bit, os_phase
  );
endinterface

// File: rtl/baud_tick_gen_mc.sv
// rtl/baud_tick_gen_mc.sv - multi-channel fractional baud tick generator
// One phase accumulator per channel; its carry is the oversample tick.
module baud_tick_gen_mc #(
  parameter int CHANNELS    = 2,
  parameter int ACC_WIDTH   = 24,
  parameter int OS_RATE     = 16,
  parameter int DEFAULT_INC = 618475,
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int OS_W        = (OS_RATE > 1) ? $clog2(OS_RATE) : 1
) (
  input logic               clk,
  input logic               rst_n,
  baud_tick_gen_mc_if.slave bus
);
  localparam logic [OS_W-1:0]      OS_LAST = OS_W'(OS_RATE - 1);
  localparam logic [OS_W-1:0]      OS_MID  = OS_W'(OS_RATE / 2);
  localparam logic [ACC_WIDTH-1:0] INC_RST = ACC_WIDTH'(DEFAULT_INC);

  logic [ACC_WIDTH-1:0] acc_q    [CHANNELS];
  logic [ACC_WIDTH-1:0] acc_d    [CHANNELS];
  logic [ACC_WIDTH-1:0] inc_q    [CHANNELS];
  logic [ACC_WIDTH-1:0] inc_d    [CHANNELS];
  logic [OS_W-1:0]      os_cnt_q [CHANNELS];
  logic [OS_W-1:0]      os_cnt_d [CHANNELS];
  logic [ACC_WIDTH:0]   sum      [CHANNELS];
  logic [CHANNELS-1:0]  tick_os_q;
  logic [CHANNELS-1:0]  tick_os_d;
  logic [CHANNELS-1:0]  tick_bit_q;
  logic [CHANNELS-1:0]  tick_bit_d;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i]        = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      acc_d[i]      = acc_q[i];
      inc_d[i]      = inc_q[i];
      os_cnt_d[i]   = os_cnt_q[i];
      tick_os_d[i]  = 1'b0;
      tick_bit_d[i] = 1'b0;

      // Accumulation below still reads inc_q, so a write lands one edge later.
      if (bus.cfg_wr && (bus.cfg_chan == CH_W'(i))) begin
        inc_d[i] = bus.cfg_inc;
      end

      if (bus.resync[i]) begin
        acc_d[i]    = '0;
        os_cnt_d[i] = OS_MID;
      end else if (!bus.enable[i]) begin
        acc_d[i]    = '0;
        os_cnt_d[i] = '0;
      end else begin
        acc_d[i]     = sum[i][ACC_WIDTH-1:0];
        tick_os_d[i] = sum[i][ACC_WIDTH];
        if (sum[i][ACC_WIDTH]) begin
          if (os_cnt_q[i] == OS_LAST) begin
            os_cnt_d[i]   = '0;
            tick_bit_d[i] = 1'b1;
          end else begin
            os_cnt_d[i] = os_cnt_q[i] + OS_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]    <= '0;
        inc_q[i]    <= INC_RST;
        os_cnt_q[i] <= '0;
      end
      tick_os_q  <= '0;
      tick_bit_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]    <= acc_d[i];
        inc_q[i]    <= inc_d[i];
        os_cnt_q[i] <= os_cnt_d[i];
      end
      tick_os_q  <= tick_os_d;
      tick_bit_q <= tick_bit_d;
    end
  end

  assign bus.tick_os  = tick_os_q;
  assign bus.tick_bit = tick_bit_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_phase
    assign bus.os_phase[g*OS_W +: OS_W] = os_cnt_q[g];
  end
endmodule

// File: tb/tb_baud_tick_gen_mc.sv
// tb/tb_baud_tick_gen_mc.sv - self-checking bench for baud_tick_gen_mc
// Three instances: default (W=24, OS=16), W=8/OS=4, and W=8/OS=16 with three channels.
module tb_baud_tick_gen_mc;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  baud_tick_gen_mc_if #(.CHANNELS(2), .ACC_WIDTH(24), .CH_W(1), .OS_W(4)) if0 ();
  baud_tick_gen_mc_if #(.CHANNELS(2), .ACC_WIDTH(8),  .CH_W(1), .OS_W(2)) if1 ();
  baud_tick_gen_mc_if #(.CHANNELS(3), .ACC_WIDTH(8),  .CH_W(2), .OS_W(4)) if2 ();

  baud_tick_gen_mc dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  baud_tick_gen_mc #(.CHANNELS(2), .ACC_WIDTH(8), .OS_RATE(4), .DEFAULT_INC(64))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  baud_tick_gen_mc #(.CHANNELS(3), .ACC_WIDTH(8), .OS_RATE(16), .DEFAULT_INC(1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [2:0]  en   [3];
  logic [2:0]  rs   [3];
  logic        wr   [3];
  logic [1:0]  chan [3];
  logic [23:0] incv [3];

  assign if0.enable = en[0][1:0];  assign if0.resync = rs[0][1:0];  assign if0.cfg_wr = wr[0];
  assign if0.cfg_chan = chan[0][0]; assign if0.cfg_inc = incv[0];
  assign if1.enable = en[1][1:0];  assign if1.resync = rs[1][1:0];  assign if1.cfg_wr = wr[1];
  assign if1.cfg_chan = chan[1][0]; assign if1.cfg_inc = incv[1][7:0];
  assign if2.enable = en[2];       assign if2.resync = rs[2];       assign if2.cfg_wr = wr[2];
  assign if2.cfg_chan = chan[2];    assign if2.cfg_inc = incv[2][7:0];

  logic [2:0] o_os  [3];
  logic [2:0] o_bit [3];
  logic [3:0] o_ph  [3][3];

  assign o_os[0] = {1'b0, if0.tick_os};  assign o_bit[0] = {1'b0, if0.tick_bit};
  assign o_os[1] = {1'b0, if1.tick_os};  assign o_bit[1] = {1'b0, if1.tick_bit};
  assign o_os[2] = if2.tick_os;          assign o_bit[2] = if2.tick_bit;
  assign o_ph[0][0] = if0.os_phase[3:0];  assign o_ph[0][1] = if0.os_phase[7:4];  assign o_ph[0][2] = 4'd0;
  assign o_ph[1][0] = {2'b00, if1.os_phase[1:0]};  assign o_ph[1][1] = {2'b00, if1.os_phase[3:2]};
  assign o_ph[1][2] = 4'd0;
  assign o_ph[2][0] = if2.os_phase[3:0];  assign o_ph[2][1] = if2.os_phase[7:4];  assign o_ph[2][2] = if2.os_phase[11:8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: ticks counted as carries of the unbounded running sum of increments.
  int     W_M   [3] = '{24, 8, 8};
  int     OS_M  [3] = '{16, 4, 16};
  int     CH_M  [3] = '{2, 2, 3};
  longint DEF_M [3] = '{618475, 64, 1};
  longint tot  [3][3];
  longint incm [3][3];
  int     cnt  [3][3];
  int     off  [3][3];
  bit     eos  [3][3];
  bit     ebit [3][3];
  int     eph  [3][3];

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 3; c++) begin
        tot[d][c] = 0; incm[d][c] = DEF_M[d]; cnt[d][c] = 0; off[d][c] = 0;
        eos[d][c] = 0; ebit[d][c] = 0; eph[d][c] = 0;
      end
    end
  endfunction

  function automatic void model_edge();
    longint nt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < CH_M[d]; c++) begin
        if (rs[d][c]) begin
          tot[d][c] = 0; cnt[d][c] = 0; off[d][c] = OS_M[d] / 2; eos[d][c] = 0; ebit[d][c] = 0;
        end else if (!en[d][c]) begin
          tot[d][c] = 0; cnt[d][c] = 0; off[d][c] = 0; eos[d][c] = 0; ebit[d][c] = 0;
        end else begin
          nt = tot[d][c] + incm[d][c];
          eos[d][c] = (nt >>> W_M[d]) != (tot[d][c] >>> W_M[d]);
          tot[d][c] = nt;
          if (eos[d][c]) cnt[d][c]++;
          ebit[d][c] = eos[d][c] && (((off[d][c] + cnt[d][c]) % OS_M[d]) == 0);
        end
        eph[d][c] = (off[d][c] + cnt[d][c]) % OS_M[d];
      end
      if (wr[d] && (int'(chan[d]) < CH_M[d]))
        incm[d][chan[d]] = longint'(incv[d]) & ((longint'(1) <<< W_M[d]) - 1);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic cfg_write(input int d, input int c, input int v);
    wr[d] = 1'b1; chan[d] = 2'(c); incv[d] = 24'(v);
    step();
    wr[d] = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (o_os[d] !== 3'b000 || o_bit[d] !== 3'b000) begin
        errors++; $display("FAIL reset_ticks dut%0d: got os=%b bit=%b want 000", d, o_os[d], o_bit[d]);
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (o_ph[d][c] !== 4'd0) begin
          errors++; $display("FAIL reset_phase dut%0d ch%0d: got %0d want 0", d, c, o_ph[d][c]);
        end
      end
    end
    @(posedge clk); #1; rst_n = 1'b1;
    cfg_write(0, 0, 1 << 23);
    en[0] = 3'b001;
    n = 0;
    while (o_os[0][0] !== 1'b1 && n < 10) begin step(); n++; end
    checks++;
    if (o_os[0][0] !== 1'b1) begin
      errors++; $display("FAIL reset_prerun_tick: got %b want 1 within 10 cycles", o_os[0][0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_os[0][0] !== 1'b0 || o_bit[0][0] !== 1'b0 || o_ph[0][0] !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: got os=%b bit=%b ph=%0d want 0 0 0", o_os[0][0], o_bit[0][0], o_ph[0][0]);
    end
    model_reset();
    en[0] = 3'b000;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_default_rate();
    int     n, first;
    longint want_n, want_first;
    n = 0; first = -1;
    en[0] = 3'b001;
    for (int k = 1; k <= 20000; k++) begin
      step();
      if (o_os[0][0] === 1'b1) begin
        n++;
        if (first < 0) first = k;
      end
    end
    en[0] = 3'b000;
    step();
    want_first = ((longint'(1) <<< 24) + 618475 - 1) / 618475;
    want_n     = (longint'(20000) * 618475) >>> 24;
    checks++;
    if (longint'(first) != want_first) begin
      errors++; $display("FAIL default_first_tick: got %0d want %0d", first, want_first);
    end
    checks++;
    if (longint'(n) != want_n) begin
      errors++; $display("FAIL default_tick_count: got %0d want %0d", n, want_n);
    end
  endtask

  task automatic test_exact_rate();
    cfg_write(1, 0, 64);
    en[1] = 3'b001;
    for (int k = 1; k <= 64; k++) begin
      step();
      checks++;
      if (o_os[1][0] !== 1'((k % 4) == 0)) begin
        errors++; $display("FAIL exact_tick_os edge%0d: got %b want %b", k, o_os[1][0], (k % 4) == 0);
      end
      checks++;
      if (o_bit[1][0] !== 1'((k % 16) == 0)) begin
        errors++; $display("FAIL exact_tick_bit edge%0d: got %b want %b", k, o_bit[1][0], (k % 16) == 0);
      end
      checks++;
      if (o_ph[1][0] !== 4'((k / 4) % 4)) begin
        errors++; $display("FAIL exact_phase edge%0d: got %0d want %0d", k, o_ph[1][0], (k / 4) % 4);
      end
    end
    en[1] = 3'b000;
    step();
  endtask

  task automatic test_fractional_rate();
    int gaps [3] = '{3, 3, 2};
    int n, last;
    bit want;
    n = 0; last = 0;
    cfg_write(2, 0, 96);
    en[2] = 3'b001;
    for (int k = 1; k <= 800; k++) begin
      step();
      want = ((k * 96) >> 8) != (((k - 1) * 96) >> 8);
      checks++;
      if (o_os[2][0] !== want) begin
        errors++; $display("FAIL frac_tick edge%0d: got %b want %b", k, o_os[2][0], want);
      end
      if (o_os[2][0] === 1'b1) begin
        checks++;
        if (k - last != gaps[n % 3]) begin
          errors++; $display("FAIL frac_gap tick%0d: got %0d want %0d", n, k - last, gaps[n % 3]);
        end
        n++; last = k;
      end
    end
    checks++;
    if (n != 300) begin
      errors++; $display("FAIL frac_count: got %0d want 300", n);
    end
    en[2] = 3'b000;
    step();
  endtask

  task automatic test_resync();
    int n;
    bit found;
    cfg_write(2, 1, 128);
    en[2] = 3'b010;
    repeat (37) step();
    rs[2] = 3'b010;
    step();
    rs[2] = 3'b000;
    checks++;
    if (o_ph[2][1] !== 4'd8 || o_os[2][1] !== 1'b0 || o_bit[2][1] !== 1'b0) begin
      errors++;
      $display("FAIL resync_state: got ph=%0d os=%b bit=%b want 8 0 0", o_ph[2][1], o_os[2][1], o_bit[2][1]);
    end
    n = 0; found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      if (o_os[2][1] === 1'b1) n++;
      if (o_bit[2][1] === 1'b1) found = 1;
    end
    checks++;
    if (!found || n != 8) begin
      errors++; $display("FAIL resync_first_bit: got bit on tick %0d (found=%0d) want tick 8", n, found);
    end
    en[2] = 3'b000; rs[2] = 3'b010;
    step();
    rs[2] = 3'b000;
    checks++;
    if (o_ph[2][1] !== 4'd8 || o_os[2][1] !== 1'b0) begin
      errors++; $display("FAIL resync_over_disable: got ph=%0d os=%b want 8 0", o_ph[2][1], o_os[2][1]);
    end
    step();
    checks++;
    if (o_ph[2][1] !== 4'd0) begin
      errors++; $display("FAIL disable_clears_phase: got %0d want 0", o_ph[2][1]);
    end
  endtask

  task automatic test_config_edges();
    int n, k;
    cfg_write(2, 1, 64);
    en[2] = 3'b010;
    repeat (3) step();
    wr[2] = 1'b1; chan[2] = 2'd1; incv[2] = 24'd32;
    step();
    wr[2] = 1'b0;
    checks++;
    if (o_os[2][1] !== 1'b1) begin
      errors++; $display("FAIL write_same_edge_old_inc: got tick %b want 1", o_os[2][1]);
    end
    wr[2] = 1'b1; chan[2] = 2'd3; incv[2] = 24'd200;
    step();
    wr[2] = 1'b0;
    k = 1;
    while (o_os[2][1] !== 1'b1 && k < 20) begin step(); k++; end
    checks++;
    if (k != 8) begin
      errors++; $display("FAIL new_inc_gap: got %0d edges want 8", k);
    end
    en[2] = 3'b111;
    for (int j = 0; j < 40; j++) begin
      step();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (o_os[2][c] !== eos[2][c] || o_ph[2][c] !== 4'(eph[2][c])) begin
          errors++;
          $display("FAIL ignored_write ch%0d: got os=%b ph=%0d want %b %0d", c, o_os[2][c], o_ph[2][c], eos[2][c], eph[2][c]);
        end
      end
    end
    en[2] = 3'b000;
    step();
    cfg_write(2, 2, 0);
    en[2] = 3'b100;
    n = 0;
    repeat (10000) begin
      step();
      if (o_os[2][2] === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL zero_inc_ticks: got %0d want 0", n);
    end
    en[2] = 3'b000;
    step();
    cfg_write(1, 1, 255);
    en[1] = 3'b010;
    n = 0;
    for (int j = 1; j <= 256; j++) begin
      step();
      if (j == 1) begin
        checks++;
        if (o_os[1][1] !== 1'b0) begin
          errors++; $display("FAIL max_inc_first_edge: got %b want 0", o_os[1][1]);
        end
      end
      if (o_os[1][1] === 1'b1) n++;
    end
    checks++;
    if (n != 255) begin
      errors++; $display("FAIL max_inc_count: got %0d want 255", n);
    end
    en[1] = 3'b000;
    step();
  endtask

  task automatic test_independence();
    cfg_write(1, 0, 64);
    en[1] = 3'b001;
    for (int j = 0; j < 3000; j++) begin
      rs[1]   = {1'b0, 1'($urandom_range(0, 15) == 0), 1'b0};
      en[1]   = {1'b0, 1'($urandom_range(0, 7) != 0), 1'b1};
      wr[1]   = 1'($urandom_range(0, 7) == 0);
      chan[1] = 2'd1;
      incv[1] = 24'($urandom_range(0, 255));
      en[2]   = 3'($urandom);
      rs[2]   = 3'($urandom) & 3'($urandom) & 3'($urandom);
      wr[2]   = 1'($urandom_range(0, 3) == 0);
      chan[2] = 2'($urandom_range(0, 3));
      incv[2] = 24'($urandom_range(0, 255));
      step();
      for (int d = 1; d < 3; d++) begin
        for (int c = 0; c < CH_M[d]; c++) begin
          checks++;
          if (o_os[d][c] !== eos[d][c] || o_bit[d][c] !== ebit[d][c] || o_ph[d][c] !== 4'(eph[d][c])) begin
            errors++;
            $display("FAIL indep dut%0d ch%0d cyc%0d: got os=%b bit=%b ph=%0d want %b %b %0d",
                     d, c, j, o_os[d][c], o_bit[d][c], o_ph[d][c], eos[d][c], ebit[d][c], eph[d][c]);
          end
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      en[d] = 3'b000; rs[d] = 3'b000; wr[d] = 1'b0;
    end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      en[d] = 3'b000; rs[d] = 3'b000; wr[d] = 1'b0; chan[d] = 2'd0; incv[d] = 24'd0;
    end
    model_reset();
    test_reset();
    test_default_rate();
    test_exact_rate();
    test_fractional_rate();
    test_resync();
    test_config_edges();
    test_independence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
